// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_t  : receiver FSM state encoding
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity mode selectors for the PARITY parameter
//   bit_clocks(): system clocks per serial bit (integer divide)
// Build option: UART_RX_PARITY_EN adds the PARITY state to the encoding.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_t;

    function automatic int bit_clocks(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// 1 so an idle (high) line is seen during and right after reset.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output (2-cycle latency)
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// UART receiver: start-bit qualification at mid-bit, LSB-first data sampling,
// optional parity check, stop-bit check, and a one-word output register with
// a valid/ready handshake and an overrun pulse when a frame has to be dropped.
//
// Parameters:
//   CLOCK_FREQ : system clock in Hz
//   BAUD_RATE  : line rate in bit/s
//   DATA_BITS  : data bits per frame (5..9)
//   PARITY     : 0 none, 1 odd, 2 even (only honoured with UART_RX_PARITY_EN)
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   uart_rx    : asynchronous serial input, idle high
//   data       : received word
//   valid      : data holds an unconsumed word
//   ready      : consumer accepts data when valid & ready
//   frame_err  : stop bit was 0 (qualified by valid)
//   parity_err : parity mismatch (qualified by valid; 0 without parity build)
//   overrun    : one-cycle pulse when a completed frame is dropped
// Build option: define UART_RX_PARITY_EN to include the parity state/check.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge
// START  | counting to mid start bit; low confirms, high rejects a glitch
// DATA   | sampling DATA_BITS data bits, one per bit period
// PARITY | sampling the parity bit (parity build only)
// STOP   | sampling the stop bit, then straight back to IDLE
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CLKS_PER_BIT = bit_clocks(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam int        PAR_MODE   = PARITY;
    localparam rx_state_t AFTER_DATA = (PAR_MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
`else
    // Parity hardware is compiled out; any PARITY setting behaves as none.
    localparam bit        PARITY_IGNORED = (PARITY != PAR_NONE);
    localparam rx_state_t AFTER_DATA     = RX_STOP;
`endif

    logic                 rx_s;
    rx_state_t            state;
    rx_state_t            state_next;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic                 ferr_q;
    logic                 load_q;

    logic at_half;
    logic at_last;
    logic last_bit;
    logic cnt_clr;
    logic smp_data;
    logic smp_par;
    logic smp_stop;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rx),
        .q     (rx_s)
    );

    assign at_half  = (cnt == CNT_HALF);
    assign at_last  = (cnt == CNT_LAST);
    assign last_bit = (bit_idx == BIT_LAST);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE: begin
                if (!rx_s) state_next = RX_START;
            end
            RX_START: begin
                if (at_half) state_next = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (at_last && last_bit) state_next = AFTER_DATA;
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (at_last) state_next = RX_STOP;
            end
`endif
            RX_STOP: begin
                if (at_last) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        cnt_clr  = 1'b0;
        smp_data = 1'b0;
        smp_par  = 1'b0;
        smp_stop = 1'b0;
        case (state)
            RX_IDLE:   cnt_clr  = 1'b1;
            // restarting at mid start bit makes every later sample land mid-bit
            RX_START:  cnt_clr  = at_half;
            RX_DATA:   smp_data = at_last;
`ifdef UART_RX_PARITY_EN
            RX_PARITY: smp_par  = at_last;
`endif
            RX_STOP:   smp_stop = at_last;
            default:   cnt_clr  = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------- bit timing and capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            if (cnt_clr || at_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state == RX_IDLE) begin
                bit_idx <= '0;
            end else if (smp_data) begin
                bit_idx <= last_bit ? '0 : bit_idx + BIT_W'(1);
            end

            // LSB arrives first, so shifting in from the top leaves it at bit 0
            if (smp_data) begin
                shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            end

            if (smp_stop) begin
                ferr_q <= ~rx_s;
            end

            // shift_q is not touched again until the next frame's first data
            // sample, so the output register can take it one cycle later
            load_q <= smp_stop;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_q;
    logic par_xor;

    assign par_xor = (^shift_q) ^ rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else if (smp_par) begin
            perr_q <= (PAR_MODE == PAR_ODD) ? ~par_xor : par_xor;
        end
    end
`endif

    // ---------------------------------------------------------------- output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            overrun   <= 1'b0;
        end else begin
            overrun <= load_q & valid & ~ready;
            if (load_q && (!valid || ready)) begin
                data      <= shift_q;
                frame_err <= ferr_q;
`ifdef UART_RX_PARITY_EN
                parity_err <= perr_q;
`endif
                valid     <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = PARITY_IGNORED & 1'b0;
`endif

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have port clk, input, 1, system clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port uart_rx, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port data, output, DATA_BITS, received word, LSB first on the line.
REQ-009 SHALL have port valid, output, 1, data holds an unconsumed word.
REQ-010 SHALL have port ready, input, 1, consumer accepts data when valid&ready.
REQ-011 SHALL have ports frame_err and parity_err, each output, 1, error status qualified by valid.
REQ-012 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.

Function
REQ-013 SHALL compute CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer divide), giving 434 at the defaults.
REQ-014 SHALL pass uart_rx through a 2-flop synchronizer; all FSM decisions use the synchronized value (2-cycle input latency).
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: on synchronized uart_rx = 0 -> START, clear bit counter.
REQ-017 START: sample at count CLKS_PER_BIT/2; rx = 1 -> IDLE (glitch rejected, no output activity); rx = 0 -> DATA, counter reset.
REQ-018 DATA: sample every CLKS_PER_BIT cycles into bit index 0..DATA_BITS-1; after the last bit go to PARITY if parity is enabled, else STOP.
REQ-019 PARITY: sample one bit; parity_err_next = 1 if the XOR of the data bits and the parity bit is 0 for odd mode, or 1 for even mode.
REQ-020 STOP: sample one bit at mid-bit; frame_err_next = (rx == 0); go to IDLE in the same cycle, so back-to-back frames resync on the next falling edge.
REQ-021 The output register SHALL load data, frame_err and parity_err, and set valid, on the cycle after the STOP sample, provided valid = 0 or ready = 1 in that cycle.
REQ-022 If valid = 1 and ready = 0 at load time, the output register SHALL keep the old word and flags, drop the new frame, and pulse overrun for one cycle.
REQ-023 valid&ready with no concurrent load SHALL clear valid on the next edge.
REQ-024 valid&ready with a concurrent load SHALL load the new word, keep valid = 1, and not assert overrun.
REQ-025 A frame with frame_err or parity_err SHALL still be delivered; errors never block the handshake.
REQ-026 data, frame_err and parity_err SHALL be stable while valid = 1 and ready = 0.
REQ-027 The baud counter SHALL be at least $clog2(CLKS_PER_BIT) bits wide and SHALL wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, counters 0, data 0, valid 0, frame_err 0, parity_err 0, overrun 0, synchronizer flops 1.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL restart only on a new falling edge.
REQ-030 Reset deassertion SHALL be used synchronously; the first active edge after release evaluates IDLE.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: the PARITY state and parity check SHALL be present, and the PARITY parameter SHALL be honoured.
REQ-032 UART_RX_PARITY_EN undefined: the PARITY state and its logic SHALL not be generated, PARITY SHALL be ignored (treated as 0), and parity_err SHALL be tied to 0.

Structure
REQ-033 Package uart_pkg SHALL hold the rx state enum and the parity mode constants PAR_NONE, PAR_ODD and PAR_EVEN.
REQ-034 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer, reset to 1; all other logic stays in uart_rx_core.

Verification (defaults unless noted; bit = 434 clk)
REQ-035 Frame 0x55 with 8N1 and ready held 1 -> valid pulses for 1 cycle, data = 0x55, frame_err = 0, parity_err = 0.
REQ-036 Low glitch of 100 clk on an idle line -> FSM returns to IDLE and valid stays 0.
REQ-037 With UART_RX_PARITY_EN defined, PARITY = 2: frame 0xA3 with a wrong parity bit -> data = 0xA3, parity_err = 1; same frame with a correct parity bit -> parity_err = 0.
REQ-038 Frame 0x3C with stop bit = 0 -> data = 0x3C, frame_err = 1, and the next frame 0x81 is received correctly.
REQ-039 ready held 0, frames 0x11 then 0x22 -> data remains 0x11, overrun pulses once; raise ready -> valid drops the next cycle.
REQ-040 rst_n asserted at DATA bit 4 of frame 0xFF, then released and frame 0x0F sent -> no output for 0xFF, data = 0x0F; DATA_BITS = 5 run with frame 0x15 -> data = 5'h15.
